// File: rtl/rtc_multi_clk_divider.sv
`timescale 1ns/1ps
// rtc_multi_clk_divider: N_CH run-time programmable square-wave / tick dividers on sys_clk (optional macro RTCDIV_CFG_ERR_EN adds cfg_err).
// Latency: clk_out is registered; divisor writes apply on the next edge when halted, else at the next wrap.
// Backpressure: none; free-running, writes are always accepted or rejected in the same cycle.
module rtc_multi_clk_divider #(
  parameter int SYS_CLK_HZ       = 1000000,
  parameter int N_CH             = 2,
  parameter int CNT_W            = 32,
  parameter int KEYCHANGE_PERIOD = 5,
  parameter int FAST_HZ          = 500
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [N_CH-1:0]  ch_mode,
  input  logic             sync_clr,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [N_CH-1:0]  clk_out
`ifdef RTCDIV_CFG_ERR_EN
  ,
  output logic             cfg_err
`endif
);

  localparam logic [CNT_W-1:0] DIV_FAST = CNT_W'(SYS_CLK_HZ / FAST_HZ);
  localparam logic [CNT_W-1:0] DIV_KEY  = CNT_W'(KEYCHANGE_PERIOD * SYS_CLK_HZ);

  // Channel 1 is the key-change timer; every other channel defaults to the fast rate.
  function automatic logic [CNT_W-1:0] rst_div(input int ch);
    return (ch == 1) ? DIV_KEY : DIV_FAST;
  endfunction

  logic [CNT_W-1:0] cnt_q     [N_CH];
  logic [CNT_W-1:0] div_act_q [N_CH];
  logic [CNT_W-1:0] div_shd_q [N_CH];
  logic [CNT_W-1:0] cnt_nxt   [N_CH];
  logic [N_CH-1:0]  halted;
  logic [N_CH-1:0]  wrap;
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  out_nxt;
  logic             cfg_ch_ok;
  logic             cfg_acc;

  assign cfg_ch_ok = ({1'b0, cfg_ch} < 5'(N_CH));

`ifdef RTCDIV_CFG_ERR_EN
  logic cfg_rej;
  assign cfg_acc = cfg_we && cfg_ch_ok && (cfg_div >= CNT_W'(2));
  assign cfg_rej = cfg_we && !cfg_acc;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_rej;
    end
  end
`else
  assign cfg_acc = cfg_we && cfg_ch_ok;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign halted[g]  = (div_act_q[g] < CNT_W'(2)) || !ch_en[g];
    assign wrap[g]    = (cnt_q[g] == div_act_q[g] - CNT_W'(1));
    assign cnt_nxt[g] = wrap[g] ? '0 : cnt_q[g] + CNT_W'(1);
    assign wr_hit[g]  = cfg_acc && (cfg_ch == 4'(g));
    // Square: low half first, odd divisors put the extra cycle in the high half.
    assign out_nxt[g] = ch_mode[g] ? wrap[g] : (cnt_nxt[g] >= (div_act_q[g] >> 1));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_out <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]     <= '0;
        div_act_q[i] <= rst_div(i);
        div_shd_q[i] <= rst_div(i);
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync_clr) begin
          cnt_q[i]     <= '0;
          clk_out[i]   <= 1'b0;
          div_act_q[i] <= wr_hit[i] ? cfg_div : div_shd_q[i];
        end else if (halted[i]) begin
          cnt_q[i]   <= '0;
          clk_out[i] <= 1'b0;
          if (wr_hit[i]) begin
            div_act_q[i] <= cfg_div;
          end
        end else begin
          cnt_q[i]   <= cnt_nxt[i];
          clk_out[i] <= out_nxt[i];
          // Only swap divisors at a period boundary so a running period is never cut short.
          if (wrap[i]) begin
            div_act_q[i] <= wr_hit[i] ? cfg_div : div_shd_q[i];
          end
        end
        if (wr_hit[i]) begin
          div_shd_q[i] <= cfg_div;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_multi_clk_divider.sv
`timescale 1ns/1ps
// Self-checking bench for rtc_multi_clk_divider at default parameters; expected outputs queued per cycle.
module tb_rtc_multi_clk_divider;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  ch_en;
  logic [1:0]  ch_mode;
  logic        sync_clr;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [1:0]  clk_out;
`ifdef RTCDIV_CFG_ERR_EN
  logic        cfg_err;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] sb[$];
  logic [1:0] exp_v;
  logic       e0;

  always #5 sys_clk = ~sys_clk;

  rtc_multi_clk_divider dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ch_en     (ch_en),
    .ch_mode   (ch_mode),
    .sync_clr  (sync_clr),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .clk_out   (clk_out)
`ifdef RTCDIV_CFG_ERR_EN
    ,
    .cfg_err   (cfg_err)
`endif
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    sync_clr  = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = 4'd0;
    cfg_div   = 32'd0;
    ch_en     = 2'b11;
    ch_mode   = 2'b00;
    #1;
    n_cmp++;
    if (clk_out !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_t0 got=%b exp=00", clk_out);
    end
    repeat (3) step();
    n_cmp++;
    if (clk_out !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_held got=%b exp=00", clk_out);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    n_cmp++;
    if (clk_out !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_release got=%b exp=00", clk_out);
    end
  endtask

  // Default divisors: ch0 2000 (low 1000 / high 1000), ch1 5,000,000 stays low here.
  task automatic test_default_square();
    for (int k = 1; k <= 4100; k++) begin
      e0 = (k % 2000) >= 1000;
      sb.push_back({1'b0, e0});
      step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (clk_out !== exp_v) begin
        n_bad++;
        $display("FAIL default_square k=%0d got=%b exp=%b", k, clk_out, exp_v);
      end
    end
  endtask

  task automatic test_pulse();
    ch_en   = 2'b10;
    cfg_we  = 1'b1;
    cfg_ch  = 4'd0;
    cfg_div = 32'd5;
    step();
    cfg_we  = 1'b0;
    ch_en   = 2'b11;
    ch_mode = 2'b01;
    n_cmp++;
    if (clk_out !== 2'b00) begin
      n_bad++;
      $display("FAIL pulse_halted got=%b exp=00", clk_out);
    end
    for (int k = 1; k <= 20; k++) begin
      e0 = (k % 5) == 0;
      sb.push_back({1'b0, e0});
      step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (clk_out !== exp_v) begin
        n_bad++;
        $display("FAIL pulse k=%0d got=%b exp=%b", k, clk_out, exp_v);
      end
    end
  endtask

  // Write div 10 at cnt=300 of a 2000 period: the 2000 period completes, then 5/5.
  task automatic test_div_change();
    ch_en   = 2'b10;
    cfg_we  = 1'b1;
    cfg_ch  = 4'd0;
    cfg_div = 32'd2000;
    step();
    cfg_we  = 1'b0;
    ch_en   = 2'b11;
    ch_mode = 2'b00;
    for (int k = 1; k <= 2030; k++) begin
      e0 = (k <= 2000) ? ((k % 2000) >= 1000) : (((k - 2000) % 10) >= 5);
      sb.push_back({1'b0, e0});
      step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (clk_out !== exp_v) begin
        n_bad++;
        $display("FAIL div_change k=%0d got=%b exp=%b", k, clk_out, exp_v);
      end
      if (k == 300) begin
        cfg_we  = 1'b1;
        cfg_div = 32'd10;
      end
      if (k == 301) cfg_we = 1'b0;
    end
  endtask

  // Div 7 (low 3 / high 4), sync_clr mid-high, then sync_clr together with a write of 4.
  task automatic test_sync_clr();
    ch_en   = 2'b10;
    cfg_we  = 1'b1;
    cfg_ch  = 4'd0;
    cfg_div = 32'd7;
    step();
    cfg_we  = 1'b0;
    ch_en   = 2'b11;
    for (int k = 1; k <= 52; k++) begin
      if (k <= 10)      e0 = (k % 7) >= 3;
      else if (k <= 31) e0 = ((k - 11) % 7) >= 3;
      else              e0 = ((k - 32) % 4) >= 2;
      sb.push_back({1'b0, e0});
      step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (clk_out !== exp_v) begin
        n_bad++;
        $display("FAIL sync_clr k=%0d got=%b exp=%b", k, clk_out, exp_v);
      end
      if (k == 10) sync_clr = 1'b1;
      if (k == 11) sync_clr = 1'b0;
      if (k == 31) begin
        sync_clr = 1'b1;
        cfg_we   = 1'b1;
        cfg_div  = 32'd4;
      end
      if (k == 32) begin
        sync_clr = 1'b0;
        cfg_we   = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    int w;
    w = 0;
    while (clk_out[0] !== 1'b1 && w < 8) begin
      step();
      w++;
    end
    n_cmp++;
    if (clk_out[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL async_precond_high got=%b exp=1", clk_out[0]);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (clk_out !== 2'b00) begin
      n_bad++;
      $display("FAIL async_reset_immediate got=%b exp=00", clk_out);
    end
    step();
    n_cmp++;
    if (clk_out !== 2'b00) begin
      n_bad++;
      $display("FAIL async_reset_held got=%b exp=00", clk_out);
    end
    @(negedge sys_clk);
    ch_mode   = 2'b00;
    ch_en     = 2'b11;
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 2100; k++) begin
      e0 = (k % 2000) >= 1000;
      sb.push_back({1'b0, e0});
      step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (clk_out !== exp_v) begin
        n_bad++;
        $display("FAIL async_reset_div_restore k=%0d got=%b exp=%b", k, clk_out, exp_v);
      end
    end
  endtask

  // Div 20 running; write div 1 to ch0 at k=5, then an out-of-range channel write at k=30.
  task automatic test_cfg_err();
    ch_en   = 2'b10;
    cfg_we  = 1'b1;
    cfg_ch  = 4'd0;
    cfg_div = 32'd20;
    step();
    cfg_we  = 1'b0;
    ch_en   = 2'b11;
    for (int k = 1; k <= 60; k++) begin
`ifdef RTCDIV_CFG_ERR_EN
      e0 = (k % 20) >= 10;
`else
      e0 = (k <= 20) ? ((k % 20) >= 10) : 1'b0;
`endif
      sb.push_back({1'b0, e0});
      step();
      exp_v = sb.pop_front();
      n_cmp++;
      if (clk_out !== exp_v) begin
        n_bad++;
        $display("FAIL cfg_write k=%0d got=%b exp=%b", k, clk_out, exp_v);
      end
`ifdef RTCDIV_CFG_ERR_EN
      n_cmp++;
      if (cfg_err !== ((k == 6) || (k == 31))) begin
        n_bad++;
        $display("FAIL cfg_err k=%0d got=%b exp=%b", k, cfg_err, ((k == 6) || (k == 31)));
      end
`endif
      if (k == 5) begin
        cfg_we  = 1'b1;
        cfg_ch  = 4'd0;
        cfg_div = 32'd1;
      end
      if (k == 6) cfg_we = 1'b0;
      if (k == 30) begin
        cfg_we  = 1'b1;
        cfg_ch  = 4'd2;
        cfg_div = 32'd3;
      end
      if (k == 31) begin
        cfg_we = 1'b0;
        cfg_ch = 4'd0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_square();
    test_pulse();
    test_div_change();
    test_sync_clr();
    test_async_reset();
    test_cfg_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
